// File: rtl/dcm_ctrl_pkg.sv
// dcm_ctrl_pkg: shared definitions for the DCM_SP reset/lock sequencer.
//   state_t              - sequencer states
//   STATUS_CLKFX_STOPPED - index of the "CLKFX stopped" bit in DCM STATUS
//   cnt_width()          - width of the shared down-counter
package dcm_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam int STATUS_CLKFX_STOPPED = 2;

    // One counter serves every timed state, so it must hold the largest
    // reload value. The extra bit keeps an exact power of two representable.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous reset.
//   clk   - destination clock
//   reset - synchronous, active-high; clears both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk edges after d
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let both flops sample on the same edge,
    // giving a true two-stage shift instead of collapsing into one flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_lock_ctrl.sv
// dcm_lock_ctrl: reset and lock sequencer for a DCM_SP.
//   clk_in    - DCM input clock (sole clock)
//   reset     - synchronous, active-high
//   locked    - DCM LOCKED (asynchronous)
//   status    - DCM STATUS (asynchronous); only the CLKFX-stopped bit is used
//   retry_req - pulse: leave FAULT and restart sequencing
//   dcm_reset - to DCM RST
//   clk_ok    - synthesised clock locked and stable
//   lock_lost - one-cycle pulse when lock or CLKFX is lost in RUN
//   fault     - retries exhausted
//   retry_cnt - failed attempts since the last fresh start
module dcm_lock_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 40000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       locked,
    input  logic [7:0] status,
    input  logic       retry_req,
    output logic       dcm_reset,
    output logic       clk_ok,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Reload values are "cycles - 1": a state is left on the edge at which
    // the counter is already zero, so it lasts exactly the nominal count.
    localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    logic          locked_s;
    logic          fxstop_s;
    logic          good;
    logic          unused_status;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_d;
    logic          lost_d;
    logic          fail;

    sync_2ff u_sync_locked (
        .clk   (clk_in),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    sync_2ff u_sync_fxstop (
        .clk   (clk_in),
        .reset (reset),
        .d     (status[STATUS_CLKFX_STOPPED]),
        .q     (fxstop_s)
    );

    assign good          = locked_s & ~fxstop_s;
    assign unused_status = ^{status[7:3], status[1:0]};

    function automatic logic [CW-1:0] entry_load(input state_t s);
        case (s)
            RST_HOLD:  return RST_LOAD;
            WAIT_LOCK: return LOCK_LOAD;
            STABLE:    return STABLE_LOAD;
            default:   return '0;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        lost_d  = 1'b0;
        fail    = 1'b0;

        case (state_q)
            RST_HOLD: begin
                if (cnt_q == '0) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Good is tested first so a lock in the last cycle still counts.
                if (good)              state_d = STABLE;
                else if (cnt_q == '0)  fail    = 1'b1;
            end
            STABLE: begin
                if (!good)             fail    = 1'b1;
                else if (cnt_q == '0)  state_d = RUN;
            end
            RUN: begin
                // A loss after a good lock is a fresh start, not a failed attempt.
                if (!good) begin
                    lost_d  = 1'b1;
                    retry_d = 4'd0;
                    state_d = RST_HOLD;
                end
            end
            FAULT: begin
                if (retry_req) begin
                    retry_d = 4'd0;
                    state_d = RST_HOLD;
                end
            end
            default: state_d = RST_HOLD;
        endcase

        if (fail) begin
            if (retry_cnt == RETRY_MAX) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_cnt + 4'd1;
                state_d = RST_HOLD;
            end
        end

        // Shared counter: reload on any state change, otherwise count down.
        if (state_d != state_q)  cnt_d = entry_load(state_d);
        else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
        else                     cnt_d = cnt_q;
    end

    // Outputs are registered from the next state so they line up with the
    // state register; FAULT -> RST_HOLD keeps dcm_reset high without a gap.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= RST_HOLD;
            cnt_q     <= RST_LOAD;
            retry_cnt <= 4'd0;
            dcm_reset <= 1'b1;
            clk_ok    <= 1'b0;
            lock_lost <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            dcm_reset <= (state_d == RST_HOLD) || (state_d == FAULT);
            clk_ok    <= (state_d == RUN);
            lock_lost <= lost_d;
            fault     <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// tb_dcm_lock_ctrl: directed bench for dcm_lock_ctrl with
// RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dcm_lock_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRY     = 2;
    localparam int BUDGET        = 300;

    // Raw locked rise -> clk_ok: 2 sync edges + 1 edge into STABLE
    // + STABLE_CYCLES edges in STABLE.
    localparam int LOCK_TO_OK = 2 + 1 + STABLE_CYCLES;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic [7:0] status;
    logic       retry_req;
    logic       dcm_reset;
    logic       clk_ok;
    logic       lock_lost;
    logic       fault;
    logic [3:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int lost_pulses = 0;
    logic clk_ok_seen = 1'b0;

    always #5 clk = ~clk;

    dcm_lock_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk_in    (clk),
        .reset     (reset),
        .locked    (locked),
        .status    (status),
        .retry_req (retry_req),
        .dcm_reset (dcm_reset),
        .clk_ok    (clk_ok),
        .lock_lost (lock_lost),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    // Sampling on the rising edge reads the value held during the prior cycle.
    always @(posedge clk) begin
        if (lock_lost === 1'b1) lost_pulses++;
        if (clk_ok === 1'b1)    clk_ok_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consecutive samples (including the current one) with dcm_reset high.
    task automatic width_high(output int w);
        w = 0;
        while (dcm_reset === 1'b1 && w < BUDGET) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic width_low(output int w);
        w = 0;
        while (dcm_reset === 1'b0 && w < BUDGET) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic edges_to_clk_ok(output int n);
        n = 0;
        while (clk_ok !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic edges_to_lost(output int n);
        n = 0;
        while (lock_lost !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic edges_to_dcm_reset(output int n);
        n = 0;
        while (dcm_reset !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int w;
        int n;
        int lost_base;

        reset     = 1'b1;
        locked    = 1'b0;
        status    = 8'h00;
        retry_req = 1'b0;
        step(3);

        // Reset state
        check("rst_dcm_reset", dcm_reset, 1);
        check("rst_clk_ok",    clk_ok,    0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_fault",     fault,     0);
        check("rst_retry_cnt", retry_cnt, 0);

        // Normal lock
        reset = 1'b0;
        width_high(w);
        check("norm_rst_width", w, RST_CYCLES);
        step(10);
        locked = 1'b1;
        edges_to_clk_ok(n);
        check("norm_lock_latency", n, LOCK_TO_OK);
        check("norm_retry_cnt",    retry_cnt, 0);
        check("norm_dcm_reset",    dcm_reset, 0);

        // Loss in RUN
        step(5);
        lost_base = lost_pulses;
        locked    = 1'b0;
        edges_to_lost(n);
        check("loss_latency",   n, 3);
        check("loss_clk_ok",    clk_ok, 0);
        check("loss_retry_cnt", retry_cnt, 0);
        width_high(w);
        check("loss_rst_width", w, RST_CYCLES);
        check("loss_pulse_cnt", lost_pulses - lost_base, 1);

        // Retry exhaustion: locked stays low, each attempt times out
        width_low(w);
        check("ret1_wait_len",  w, LOCK_TIMEOUT);
        check("ret1_retry_cnt", retry_cnt, 1);
        width_high(w);
        check("ret1_rst_width", w, RST_CYCLES);
        width_low(w);
        check("ret2_wait_len",  w, LOCK_TIMEOUT);
        check("ret2_retry_cnt", retry_cnt, 2);
        width_high(w);
        check("ret2_rst_width", w, RST_CYCLES);
        width_low(w);
        check("ret3_wait_len",  w, LOCK_TIMEOUT);
        check("ret3_fault",     fault, 1);
        check("ret3_retry_cnt", retry_cnt, MAX_RETRY);
        check("ret3_clk_ok",    clk_ok, 0);
        step(20);
        check("fault_hold_dcm_reset", dcm_reset, 1);
        check("fault_hold_fault",     fault, 1);

        // Fault recovery
        retry_req = 1'b1;
        step(1);
        retry_req = 1'b0;
        check("rec_retry_cnt", retry_cnt, 0);
        check("rec_fault",     fault, 0);
        width_high(w);
        check("rec_rst_width", w, RST_CYCLES);
        locked = 1'b1;
        edges_to_clk_ok(n);
        check("rec_lock_latency", n, LOCK_TO_OK);

        // Status bits other than CLKFX-stopped are ignored
        status = 8'hFB;
        step(5);
        check("status_other_clk_ok", clk_ok, 1);

        // CLKFX stop in RUN behaves like loss of lock
        lost_base = lost_pulses;
        status    = 8'hFF;
        edges_to_lost(n);
        check("fx_latency",   n, 3);
        check("fx_clk_ok",    clk_ok, 0);
        check("fx_retry_cnt", retry_cnt, 0);
        width_high(w);
        check("fx_rst_width", w, RST_CYCLES);
        check("fx_pulse_cnt", lost_pulses - lost_base, 1);

        // Glitch in STABLE: fxstop_s clears after 2 edges, STABLE entered on
        // the third with the counter at 15; five more edges bring it to 10.
        status      = 8'h00;
        clk_ok_seen = 1'b0;
        lost_base   = lost_pulses;
        step(3 + 5);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        // locked_s drops one edge from now; the FSM fails on the edge after.
        edges_to_dcm_reset(n);
        check("glitch_latency",   n, 2);
        check("glitch_retry_cnt", retry_cnt, 1);
        check("glitch_clk_ok",    clk_ok_seen, 0);
        check("glitch_no_lost",   lost_pulses - lost_base, 0);
        locked = 1'b0;
        width_high(w);
        check("glitch_rst_width", w, RST_CYCLES);

        // Reset mid-WAIT_LOCK
        step(10);
        check("wait_dcm_reset", dcm_reset, 0);
        reset = 1'b1;
        step(1);
        check("mid_rst_dcm_reset", dcm_reset, 1);
        check("mid_rst_clk_ok",    clk_ok, 0);
        check("mid_rst_lock_lost", lock_lost, 0);
        check("mid_rst_fault",     fault, 0);
        check("mid_rst_retry_cnt", retry_cnt, 0);
        reset = 1'b0;
        width_high(w);
        check("mid_rst_width", w, RST_CYCLES);

        // retry_req outside FAULT has no effect
        retry_req = 1'b1;
        step(1);
        retry_req = 1'b0;
        step(1);
        check("retry_ignored_dcm_reset", dcm_reset, 0);
        check("retry_ignored_retry_cnt", retry_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcm_lock_ctrl.md
# dcm_lock_ctrl

Reset and lock sequencer for the DCM_SP clock synthesiser. Runs on the DCM input clock and drives the DCM reset, holding it for a fixed minimum time. It then waits for LOCKED with a timeout and requires the lock to stay stable before declaring the synthesised clock good. After that it monitors for loss of lock or a stopped CLKFX, retries a bounded number of times, and latches a fault if the DCM never locks.

## Interface
- RST_CYCLES, 8: cycles dcm_reset is held high per attempt (DCM_SP needs ≥3 CLKIN cycles); legal ≥3.
- LOCK_TIMEOUT, 40000: cycles allowed in WAIT_LOCK per attempt (1 ms at 40 MHz).
- STABLE_CYCLES, 64: consecutive cycles locked must stay high before clk_ok asserts; legal ≥1.
- MAX_RETRY, 7: failed attempts allowed before FAULT; legal 0..15.
- clk_in  in  1  DCM input clock; sole clock of this block.
- reset  in  1  synchronous, active-high reset.
- locked  in  1  DCM LOCKED; asynchronous to this block.
- status  in  8  DCM STATUS; only bit 2 (CLKFX stopped) is used; asynchronous.
- retry_req  in  1  single-cycle pulse that leaves FAULT and restarts sequencing.
- dcm_reset  out  1  to DCM RST.
- clk_ok  out  1  synthesised clock is locked and stable.
- lock_lost  out  1  one-cycle pulse on loss of lock or CLKFX stop while in RUN.
- fault  out  1  retries exhausted.
- retry_cnt  out  4  failed attempts since the last fresh start.

## Operation
- locked and status[2] each pass through a 2-flop synchronizer. The synchronized values are locked_s and fxstop_s.
- "Good" means locked_s=1 and fxstop_s=0.
- One down-counter `cnt` is shared by all states. It is reloaded on every state entry.
- **RST_HOLD:** dcm_reset=1. Stays RST_CYCLES cycles, then goes to WAIT_LOCK.
- **WAIT_LOCK:** dcm_reset=0.
  - Good → STABLE.
  - LOCK_TIMEOUT cycles elapse without good → fail path.
- **STABLE:** dcm_reset=0.
  - Good for STABLE_CYCLES consecutive cycles → RUN.
  - Any not-good cycle → fail path.
- **RUN:** clk_ok=1.
  - Any not-good cycle → lock_lost pulses for 1 cycle, retry_cnt clears to 0, next state is RST_HOLD.
  - Loss after a successful lock counts as a fresh start, not a failed attempt.
- **Fail path:**
  - If retry_cnt == MAX_RETRY → FAULT.
  - Otherwise retry_cnt increments and the next state is RST_HOLD.
- **FAULT:** dcm_reset=1, fault=1, clk_ok=0.
  - retry_req → retry_cnt=0, next state RST_HOLD.
  - retry_req is ignored in every other state.
- retry_cnt saturates at MAX_RETRY. With MAX_RETRY=0 the first failure goes straight to FAULT.
- Values of status bits other than 2 have no effect.

## Timing
- **Reset values:** state=RST_HOLD, dcm_reset=1, clk_ok=0, lock_lost=0, fault=0, retry_cnt=0, synchronizers=0.
- Asserting reset mid-operation forces these values on the next edge from any state.
- All outputs are registered and take their state's value in the cycle after the transition edge.
- **dcm_reset width:**
  - Exactly RST_CYCLES cycles when entering from reset or from a retry.
  - Entering from FAULT, dcm_reset stays continuously high through the FAULT → RST_HOLD boundary, for RST_CYCLES more cycles.
- **Lock latency:** a locked rising edge arriving during WAIT_LOCK reaches locked_s 2 cycles later. clk_ok asserts STABLE_CYCLES+1 cycles after locked_s rises.
- **Loss latency:** locked falling in RUN reaches locked_s in 2 cycles. clk_ok deasserts and lock_lost pulses on the next edge, 3 cycles after the raw input falls.
- **Timeout:** the fail transition occurs on the edge at which WAIT_LOCK has lasted LOCK_TIMEOUT cycles.
- **Simultaneous events:**
  - Good and timeout in the same cycle → good wins (go to STABLE).
  - reset and retry_req together → reset wins.
- Counter width is $clog2 of the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1.

## Structure
- **Package dcm_ctrl_pkg:**
  - State encoding (RST_HOLD, WAIT_LOCK, STABLE, RUN, FAULT).
  - STATUS_CLKFX_STOPPED = 2.
  - Counter width function.
- **Sub-module sync_2ff:** single-bit 2-flop synchronizer with synchronous reset, instantiated twice.
- Top level contains the FSM, the shared counter and retry_cnt.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=2.
- **Normal lock:** release reset; raise locked 10 cycles after dcm_reset falls → dcm_reset high exactly 4 cycles; clk_ok rises 2+16+1 cycles after locked rises; retry_cnt=0.
- **Retry exhaustion:** locked held 0 → three dcm_reset pulses of 4 cycles, spaced 100 cycles apart; retry_cnt goes 1, then 2; after the third timeout fault=1 and dcm_reset stays high.
- **Fault recovery:** from FAULT, pulse retry_req, then raise locked → retry_cnt=0; dcm_reset stays high 4 more cycles then falls; clk_ok asserts as in the normal-lock scenario.
- **Loss in RUN:** in RUN, drop locked → lock_lost one-cycle pulse 3 cycles later; clk_ok=0; dcm_reset=1 for 4 cycles; retry_cnt=0.
- **Glitch in STABLE:** in STABLE, drop locked for 1 cycle at count 10 → retry_cnt=1, re-enter RST_HOLD, clk_ok never asserts.
- **Reset and CLKFX stop:** in RUN set status[2]=1 → same response as loss in RUN. Assert reset mid-WAIT_LOCK → all outputs return to their reset values on the next edge.
